// File: rtl/spypath_sched_pkg.sv
// Shared types and helpers for the spy-path delay scheduler.
package spypath_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_LAUNCH,
    S_SETTLE,
    S_CAPTURE,
    S_EVAL,
    S_DONE
  } state_e;

  localparam int DEF_NUM_PATHS = 8;
  localparam int DEF_REP_W     = 16;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_SETTLE_W  = 4;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [32:0] max_v;
    max_v = (33'd1 << w) - 33'd1;
    return (33'(v) >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pd_settle_timer.sv
// Loadable down-counter timing the settle window between launch and capture.
module pd_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = value;
    else if (count_q != '0)
      count_d = count_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expire = (count_q <= W'(1));

endmodule

// File: rtl/spypath_delay_scheduler.sv
// Sequences launch transitions through enabled spy paths and counts late/wrong captures.
module spypath_delay_scheduler
  import spypath_sched_pkg::*;
#(
  parameter int NUM_PATHS = DEF_NUM_PATHS,
  parameter int REP_W     = DEF_REP_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int SETTLE_W  = DEF_SETTLE_W,
  parameter int RD_W      = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [REP_W-1:0]     cfg_reps,
  input  logic [SETTLE_W-1:0]  cfg_settle,
  input  logic [NUM_PATHS-1:0] cfg_mask,
  input  logic [NUM_PATHS-1:0] cfg_pol,
  output logic [NUM_PATHS-1:0] launch,
  input  logic [NUM_PATHS-1:0] path_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err_any,
  input  logic [RD_W-1:0]      rd_idx,
  output logic [CNT_W-1:0]     rd_cnt
);

  // Index must be able to point one past the last path to signal end of search.
  localparam int IDX_W = $clog2(NUM_PATHS + 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [REP_W-1:0]     reps_q, reps_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic [NUM_PATHS-1:0] mask_q, mask_d;
  logic [NUM_PATHS-1:0] pol_q, pol_d;
  logic [NUM_PATHS-1:0] launch_q, launch_d;
  logic                 err_q, err_d;
  logic                 cap_q, cap_d;
  logic [REP_W:0]       trans_q, trans_d;
  logic [CNT_W-1:0]     cnt_q [NUM_PATHS];
  logic [CNT_W-1:0]     cnt_d [NUM_PATHS];

  logic [RD_W-1:0]      sel;
  logic [SETTLE_W-1:0]  s_eff;
  logic                 found;
  logic [IDX_W-1:0]     seek_idx;
  logic                 tmr_load;
  logic                 tmr_expire;

  assign sel   = idx_q[RD_W-1:0];
  assign s_eff = (settle_q == '0) ? SETTLE_W'(1) : settle_q;

  always_comb begin
    found    = 1'b0;
    seek_idx = idx_q;
    for (int i = 0; i < NUM_PATHS; i++) begin
      if (!found && (i >= int'(idx_q)) && mask_q[i]) begin
        found    = 1'b1;
        seek_idx = IDX_W'(i);
      end
    end
  end

  // The timer covers the SETTLE cycles only; CAPTURE supplies the final settle edge.
  pd_settle_timer #(.W(SETTLE_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (s_eff - SETTLE_W'(1)),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    reps_d   = reps_q;
    settle_d = settle_q;
    mask_d   = mask_q;
    pol_d    = pol_q;
    launch_d = launch_q;
    err_d    = err_q;
    cap_d    = cap_q;
    trans_d  = trans_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          reps_d   = cfg_reps;
          settle_d = cfg_settle;
          mask_d   = cfg_mask;
          pol_d    = cfg_pol;
          for (int i = 0; i < NUM_PATHS; i++) cnt_d[i] = '0;
          err_d    = 1'b0;
          idx_d    = '0;
          trans_d  = '0;
          launch_d = '0;
          state_d  = S_SEEK;
        end
      end
      S_SEEK: begin
        trans_d = '0;
        if (!found || (reps_q == '0)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = seek_idx;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        launch_d[sel] = ~launch_q[sel];
        tmr_load      = 1'b1;
        state_d       = (s_eff == SETTLE_W'(1)) ? S_CAPTURE : S_SETTLE;
      end
      S_SETTLE: begin
        if (tmr_expire) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        cap_d   = path_out[sel];
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (cap_q != (launch_q[sel] ^ pol_q[sel])) begin
          cnt_d[sel] = CNT_W'(sat_inc(32'(cnt_q[sel]), CNT_W));
          err_d      = 1'b1;
        end
        // An even number of toggles leaves the launch level back at 0.
        if ((trans_q + (REP_W+1)'(1)) == {reps_q, 1'b0}) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SEEK;
        end else begin
          trans_d = trans_q + (REP_W+1)'(1);
          state_d = S_LAUNCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      reps_q   <= '0;
      settle_q <= '0;
      mask_q   <= '0;
      pol_q    <= '0;
      launch_q <= '0;
      err_q    <= 1'b0;
      cap_q    <= 1'b0;
      trans_q  <= '0;
      for (int i = 0; i < NUM_PATHS; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      reps_q   <= reps_d;
      settle_q <= settle_d;
      mask_q   <= mask_d;
      pol_q    <= pol_d;
      launch_q <= launch_d;
      err_q    <= err_d;
      cap_q    <= cap_d;
      trans_q  <= trans_d;
      for (int i = 0; i < NUM_PATHS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign launch  = launch_q;
  assign err_any = err_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done    = (state_q == S_DONE);

  always_comb begin
    rd_cnt = '0;
    if (32'(rd_idx) < NUM_PATHS) rd_cnt = cnt_q[rd_idx];
  end

endmodule

// File: tb/tb_spypath_delay_scheduler.sv
// Randomised and directed bench for spypath_delay_scheduler with a behavioural path model.
module tb_spypath_delay_scheduler;

  localparam int N  = 4;
  localparam int N2 = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   cfg_reps = '0;
  logic [3:0]    cfg_settle = '0;
  logic [N-1:0]  cfg_mask = '0, cfg_pol = '0;
  logic [N-1:0]  launch, path_out;
  logic          busy, done, err_any;
  logic [1:0]    rd_idx = '0;
  logic [15:0]   rd_cnt;

  logic [N2-1:0] cfg_mask2 = '0, cfg_pol2 = '0;
  logic [N2-1:0] launch2;
  logic [N2-1:0] path_out2 = '0;
  logic          busy2, done2, err2;
  logic [2:0]    rd_idx2 = '0;
  logic [2:0]    rd_cnt2;

  logic [N-1:0]  inv = '1;
  int            dly [N];
  logic [N-1:0]  h1 = '0, h2 = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  spypath_delay_scheduler #(.NUM_PATHS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_reps(cfg_reps), .cfg_settle(cfg_settle),
    .cfg_mask(cfg_mask), .cfg_pol(cfg_pol), .launch(launch), .path_out(path_out),
    .busy(busy), .done(done), .err_any(err_any), .rd_idx(rd_idx), .rd_cnt(rd_cnt)
  );

  spypath_delay_scheduler #(.NUM_PATHS(N2), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .cfg_reps(cfg_reps), .cfg_settle(cfg_settle),
    .cfg_mask(cfg_mask2), .cfg_pol(cfg_pol2), .launch(launch2), .path_out(path_out2),
    .busy(busy2), .done(done2), .err_any(err2), .rd_idx(rd_idx2), .rd_cnt(rd_cnt2)
  );

  // Path model: buffer or inverter whose output is valid D edges after the launch edge.
  always @(posedge clk) begin
    h1 <= launch;
    h2 <= h1;
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      path_out[i] = inv[i] ^ ((dly[i] == 1) ? launch[i] : (dly[i] == 2) ? h1[i] : h2[i]);
  end

  function automatic int eff_s(input int settle);
    return (settle == 0) ? 1 : settle;
  endfunction

  // Count of wrong captures: transition k drives level k%2; a path slower than the
  // settle window shows the previous level instead.
  function automatic int model_cnt(input int i, input int reps, input int s, input int maxv);
    int c, lvl, seen;
    c = 0;
    if (!cfg_mask[i]) return 0;
    for (int k = 1; k <= 2 * reps; k++) begin
      lvl  = k % 2;
      seen = (dly[i] <= s) ? lvl : 1 - lvl;
      if ((seen ^ int'(inv[i])) != (lvl ^ int'(cfg_pol[i])))
        c = (c >= maxv) ? maxv : c + 1;
    end
    return c;
  endfunction

  // Cycle (counted from the start-accepting edge) in which done is high.
  function automatic int model_cycles(input int reps, input int s, input int nen);
    if (reps == 0) return 2;
    return nen * (1 + 2 * reps * (s + 2)) + 2;
  endfunction

  task automatic do_scan(input int limit, input int extra_start,
                         output int dc, output int nd, output int dc2,
                         output logic busy_c1, output logic busy_at_done, output logic toggled);
    dc = -1; nd = 0; dc2 = -1; busy_c1 = 1'b0; busy_at_done = 1'b1; toggled = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (c > 1) @(negedge clk);
      start = (c == extra_start);
      if (c == 1) busy_c1 = busy;
      if (done) begin
        nd++;
        if (dc < 0) begin dc = c; busy_at_done = busy; end
      end
      if (done2 && dc2 < 0) dc2 = c;
      if (launch != '0) toggled = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({launch, busy, done, err_any} !== '0)
      $display("FAIL reset_outputs got launch=%b busy=%b done=%b err=%b want all 0", launch, busy, done, err_any);
    else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      rd_idx = 2'(i); #1;
      total_cnt++;
      if (rd_cnt !== 16'd0) $display("FAIL reset_cnt[%0d] got %0d want 0", i, rd_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic run_and_check(input string tag, input int reps, input int settle, input int extra_start);
    int dc, nd, dc2, exp_c, nen, s, ec;
    logic bc1, bd, tog, exp_err;
    s = eff_s(settle);
    nen = $countones(cfg_mask);
    cfg_reps = 16'(reps); cfg_settle = 4'(settle); cfg_mask2 = '0;
    exp_c = model_cycles(reps, s, nen);
    do_scan(2 * exp_c + 10, extra_start, dc, nd, dc2, bc1, bd, tog);
    total_cnt++;
    if (dc !== exp_c) $display("FAIL %s done_cycle got %0d want %0d", tag, dc, exp_c);
    else pass_cnt++;
    total_cnt++;
    if (nd !== 1 || bd !== 1'b0 || bc1 !== 1'b1)
      $display("FAIL %s done_pulse got n=%0d busy_at_done=%b busy_c1=%b want 1/0/1", tag, nd, bd, bc1);
    else pass_cnt++;
    total_cnt++;
    if (launch !== '0) $display("FAIL %s launch_end got %b want 0", tag, launch);
    else pass_cnt++;
    exp_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      ec = model_cnt(i, reps, s, 65535);
      if (ec != 0) exp_err = 1'b1;
      rd_idx = 2'(i); #1;
      total_cnt++;
      if (rd_cnt !== 16'(ec)) $display("FAIL %s cnt[%0d] got %0d want %0d", tag, i, rd_cnt, ec);
      else pass_cnt++;
    end
    total_cnt++;
    if (err_any !== exp_err) $display("FAIL %s err_any got %b want %b", tag, err_any, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_pass;
    cfg_mask = 4'b0101; cfg_pol = 4'b0101; inv = '1;
    for (int i = 0; i < N; i++) dly[i] = 2;
    run_and_check("pass", 3, 2, 0);
  endtask

  task automatic test_slow_path;
    dly[2] = 3;
    run_and_check("slow", 3, 2, 0);
    dly[2] = 2;
  endtask

  task automatic test_settle_zero;
    cfg_mask = 4'b1111; cfg_pol = 4'b1111; inv = '1;
    for (int i = 0; i < N; i++) dly[i] = 1;
    run_and_check("settle0", 2, 0, 0);
  endtask

  task automatic test_reps_zero;
    int dc, nd, dc2;
    logic bc1, bd, tog;
    cfg_mask = 4'b1111; cfg_reps = '0; cfg_settle = 4'd2; cfg_mask2 = '0;
    do_scan(20, 0, dc, nd, dc2, bc1, bd, tog);
    total_cnt++;
    if (dc !== 2 || nd !== 1) $display("FAIL reps0_done got cycle=%0d n=%0d want 2/1", dc, nd);
    else pass_cnt++;
    total_cnt++;
    if (tog !== 1'b0) $display("FAIL reps0_launch got toggled=%b want 0", tog);
    else pass_cnt++;
  endtask

  task automatic test_saturation;
    int dc, nd, dc2, exp_c2;
    logic bc1, bd, tog;
    cfg_mask = '0; cfg_mask2 = 5'b10011; cfg_pol2 = '0;
    cfg_reps = 16'd8; cfg_settle = 4'd1;
    exp_c2 = 3 * (1 + 2 * 8 * 3) + 2;
    do_scan(exp_c2 + 10, 0, dc, nd, dc2, bc1, bd, tog);
    total_cnt++;
    if (dc2 !== exp_c2) $display("FAIL sat_done_cycle got %0d want %0d", dc2, exp_c2);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      rd_idx2 = 3'(i); #1;
      total_cnt++;
      if (rd_cnt2 !== ((i == 0 || i == 1 || i == 4) ? 3'd7 : 3'd0))
        $display("FAIL sat_cnt[%0d] got %0d want %0d", i, rd_cnt2, (i == 0 || i == 1 || i == 4) ? 7 : 0);
      else pass_cnt++;
    end
    total_cnt++;
    if (launch2 !== '0 || err2 !== 1'b1) $display("FAIL sat_end got launch=%b err=%b want 0/1", launch2, err2);
    else pass_cnt++;
    cfg_mask2 = '0;
  endtask

  task automatic test_random;
    for (int t = 0; t < 6; t++) begin
      cfg_mask = 4'($urandom_range(0, 15));
      cfg_pol  = 4'($urandom_range(0, 15));
      inv      = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(1, 3));
      run_and_check($sformatf("rand%0d", t), int'($urandom_range(1, 4)), int'($urandom_range(0, 4)), 0);
    end
  endtask

  task automatic test_reset_mid;
    int nd;
    cfg_mask = 4'b0011; cfg_pol = 4'b0001; inv = '0;
    for (int i = 0; i < N; i++) dly[i] = 1;
    cfg_reps = 16'd1; cfg_settle = 4'd8; cfg_mask2 = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    // Cycle 1 is SEEK; path 0 spans 2..21, path 1 launches at 23 and settles 24..30.
    for (int c = 2; c <= 26; c++) @(negedge clk);
    rd_idx = 2'd0; #1;
    total_cnt++;
    if (launch !== 4'b0010 || busy !== 1'b1 || rd_cnt !== 16'(model_cnt(0, 1, 8, 65535)))
      $display("FAIL pre_reset got launch=%b busy=%b cnt0=%0d want 0010/1/%0d", launch, busy, rd_cnt, model_cnt(0, 1, 8, 65535));
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (launch !== '0 || busy !== 1'b0 || done !== 1'b0 || err_any !== 1'b0)
      $display("FAIL mid_reset got launch=%b busy=%b done=%b err=%b want 0", launch, busy, done, err_any);
    else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      rd_idx = 2'(i); #1;
      total_cnt++;
      if (rd_cnt !== 16'd0) $display("FAIL mid_reset_cnt[%0d] got %0d want 0", i, rd_cnt);
      else pass_cnt++;
    end
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    total_cnt++;
    if (nd !== 0) $display("FAIL mid_reset_quiet got %0d active cycles want 0", nd);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored;
    cfg_mask = 4'b0101; cfg_pol = 4'b0101; inv = '1;
    for (int i = 0; i < N; i++) dly[i] = 2;
    dly[2] = 3;
    run_and_check("busy_start", 3, 2, 10);
    dly[2] = 2;
  endtask

  initial begin
    for (int i = 0; i < N; i++) dly[i] = 1;
    test_reset();
    test_pass();
    test_slow_path();
    test_settle_zero();
    test_reps_zero();
    test_saturation();
    test_random();
    test_reset_mid();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
